// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked RV32I ALU, iterative mul/div when ALU_MULDIV_EN is defined
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic [4:0]       i_alu_op,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_alu_res,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_illegal
);
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_XOR   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] ld_res;
    logic             ld_ovf;
    logic             ld_ill;
    logic [WIDTH-1:0] base_res;
    logic             base_ovf;
    logic             base_ill;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;

    assign accept = i_valid && o_ready;
    assign shamt  = i_operand_b[SHW-1:0];
    assign sum    = i_operand_a + i_operand_b;
    assign diff   = i_operand_a - i_operand_b;

    always_comb begin
        base_res = '0;
        base_ovf = 1'b0;
        base_ill = 1'b0;
        case (i_alu_op)
            OP_ADD: begin
                base_res = sum;
                base_ovf = (i_operand_a[WIDTH-1] == i_operand_b[WIDTH-1]) &&
                           (sum[WIDTH-1] != i_operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                base_res = diff;
                base_ovf = (i_operand_a[WIDTH-1] != i_operand_b[WIDTH-1]) &&
                           (diff[WIDTH-1] != i_operand_a[WIDTH-1]);
            end
            OP_XOR:  base_res = i_operand_a ^ i_operand_b;
            OP_OR:   base_res = i_operand_a | i_operand_b;
            OP_AND:  base_res = i_operand_a & i_operand_b;
            OP_SLL:  base_res = i_operand_a << shamt;
            OP_SRL:  base_res = i_operand_a >> shamt;
            OP_SRA:  base_res = $unsigned($signed(i_operand_a) >>> shamt);
            OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(i_operand_a) < $signed(i_operand_b)};
            OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, i_operand_a < i_operand_b};
            default: base_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [4:0] OP_MUL   = 5'd16;
    localparam logic [4:0] OP_MULHU = 5'd17;
    localparam logic [4:0] OP_DIV   = 5'd18;
    localparam logic [4:0] OP_DIVU  = 5'd19;
    localparam logic [4:0] OP_REM   = 5'd20;
    localparam logic [4:0] OP_REMU  = 5'd21;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state, state_nx;

    logic               is_md;
    logic               md_load;
    logic               signed_div;
    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [4:0]         md_op;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvsr;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH-1:0]   md_res;

    assign is_md      = (i_alu_op >= OP_MUL) && (i_alu_op <= OP_REMU);
    assign signed_div = (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);
    assign sgn_a      = signed_div && i_operand_a[WIDTH-1];
    assign sgn_b      = signed_div && i_operand_b[WIDTH-1];
    assign mag_a      = sgn_a ? -i_operand_a : i_operand_a;
    assign mag_b      = sgn_b ? -i_operand_b : i_operand_b;
    // Restoring step: partial remainder shifted left with next dividend bit, minus divisor
    assign trial      = {1'b0, rem, quo[WIDTH-1]} - {2'b00, dvsr};
    assign md_load    = (state == FIX) && (!o_valid || i_ready);
    assign o_ready    = (state == IDLE) && (!o_valid || i_ready);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_md) state_nx = ITER;
            ITER:    if (cnt == '0) state_nx = FIX;
            FIX:     if (md_load) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            md_op    <= '0;
            cnt      <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept && is_md) begin
            md_op    <= i_alu_op;
            cnt      <= SHW'(WIDTH-1);
            prod     <= '0;
            mcand    <= {{WIDTH{1'b0}}, i_operand_a};
            mplier   <= i_operand_b;
            quo      <= mag_a;
            rem      <= '0;
            dvsr     <= mag_b;
            neg_q    <= sgn_a ^ sgn_b;
            neg_r    <= sgn_a;
            div_zero <= (i_operand_b == '0);
        end else if (state == ITER) begin
            cnt    <= cnt - 1'b1;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (mplier[0]) prod <= prod + mcand;
            if (!trial[WIDTH+1]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Signed divide by zero must still give all ones, so it bypasses the quotient negation
    always_comb begin
        md_res = '0;
        case (md_op)
            OP_MUL:   md_res = prod[WIDTH-1:0];
            OP_MULHU: md_res = prod[2*WIDTH-1:WIDTH];
            OP_DIV:   md_res = div_zero ? '1 : (neg_q ? -quo : quo);
            OP_DIVU:  md_res = quo;
            OP_REM:   md_res = neg_r ? -rem : rem;
            OP_REMU:  md_res = rem;
            default:  md_res = '0;
        endcase
    end

    assign load   = (accept && !is_md) || md_load;
    assign ld_res = md_load ? md_res : base_res;
    assign ld_ovf = md_load ? 1'b0 : base_ovf;
    assign ld_ill = md_load ? 1'b0 : base_ill;
`else
    assign o_ready = !o_valid || i_ready;
    assign load    = accept;
    assign ld_res  = base_res;
    assign ld_ovf  = base_ovf;
    assign ld_ill  = base_ill;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_alu_res  <= '0;
            o_overflow <= 1'b0;
            o_zero     <= 1'b0;
            o_illegal  <= 1'b0;
        end else if (load) begin
            o_valid    <= 1'b1;
            o_alu_res  <= ld_res;
            o_overflow <= ld_ovf;
            o_zero     <= (ld_res == '0);
            o_illegal  <= ld_ill;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed bench for alu_seq, WIDTH=32 and WIDTH=8 instances
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, rdy_in = 1'b1;
    logic [31:0] opa = '0, opb = '0;
    logic [4:0]  op = '0;
    logic        o_ready, o_valid, o_overflow, o_zero, o_illegal;
    logic [31:0] o_res;

    logic        valid8 = 1'b0, rdy8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [4:0]  op8 = '0;
    logic        ready8, ovalid8, ovf8, zero8, ill8;
    logic [7:0]  res8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
        .i_operand_a(opa), .i_operand_b(opb), .i_alu_op(op),
        .o_valid(o_valid), .i_ready(rdy_in), .o_alu_res(o_res),
        .o_overflow(o_overflow), .o_zero(o_zero), .o_illegal(o_illegal)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid8), .o_ready(ready8),
        .i_operand_a(a8), .i_operand_b(b8), .i_alu_op(op8),
        .o_valid(ovalid8), .i_ready(rdy8), .o_alu_res(res8),
        .o_overflow(ovf8), .o_zero(zero8), .o_illegal(ill8)
    );

    task automatic send(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic send8(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        valid8 = 1'b1; op8 = o; a8 = a; b8 = b;
        @(posedge clk); #1;
        valid8 = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n, output bit rdy_seen);
        n = 0; rdy_seen = 1'b0;
        while (!o_valid && n < limit) begin
            if (o_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", o_valid); end
        n_cmp++; if (o_res !== 32'h0) begin n_bad++; $display("FAIL rst_res got %h want 0", o_res); end
        n_cmp++; if ({o_overflow, o_zero, o_illegal} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {o_overflow, o_zero, o_illegal}); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", o_ready); end
    endtask

    task automatic test_base_ops;
        logic [4:0]  t_op  [12];
        logic [31:0] t_a   [12];
        logic [31:0] t_b   [12];
        logic [31:0] t_res [12];
        logic [2:0]  t_fl  [12];
        t_op  = '{5'd0, 5'd1, 5'd1, 5'd7, 5'd8, 5'd9, 5'd5, 5'd6, 5'd2, 5'd3, 5'd4, 5'd12};
        t_a   = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'd1, 32'h80000000, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd9};
        t_b   = '{32'd1, 32'd5, 32'd1, 32'd31, 32'd1, 32'd1, 32'h24, 32'd4, 32'hFF00, 32'hFF00, 32'hFF00, 32'd3};
        t_res = '{32'h80000000, 32'h0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0,
                  32'h10, 32'h08000000, 32'h0FF0, 32'hFFF0, 32'hF000, 32'h0};
        // flags: {overflow, zero, illegal}
        t_fl  = '{3'b100, 3'b010, 3'b100, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011};
        for (int i = 0; i < 12; i++) begin
            send(t_op[i], t_a[i], t_b[i]);
            n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL base%0d_valid got %b want 1", i, o_valid); end
            n_cmp++; if (o_res !== t_res[i]) begin n_bad++; $display("FAIL base%0d_res got %h want %h", i, o_res, t_res[i]); end
            n_cmp++; if ({o_overflow, o_zero, o_illegal} !== t_fl[i]) begin n_bad++; $display("FAIL base%0d_flags got %b want %b", i, {o_overflow, o_zero, o_illegal}, t_fl[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  t_op  [4];
        logic [31:0] t_a   [4];
        logic [31:0] t_b   [4];
        logic [31:0] t_res [4];
        t_op  = '{5'd0, 5'd1, 5'd2, 5'd5};
        t_a   = '{32'd1, 32'd3, 32'hA, 32'd1};
        t_b   = '{32'd2, 32'd5, 32'h5, 32'd31};
        t_res = '{32'd3, 32'hFFFFFFFE, 32'hF, 32'h80000000};
        rdy_in = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; op = t_op[i]; opa = t_a[i]; opb = t_b[i];
            @(posedge clk); #1;
            n_cmp++; if (o_valid !== 1'b1 || o_res !== t_res[i]) begin n_bad++; $display("FAIL b2b%0d got v=%b %h want v=1 %h", i, o_valid, o_res, t_res[i]); end
            @(negedge clk);
        end
        valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b want 0", o_valid); end
    endtask

    task automatic test_backpressure;
        send(5'd0, 32'd1, 32'd2);
        @(negedge clk);
        rdy_in = 1'b0; valid = 1'b1; op = 5'd1; opa = 32'd10; opb = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (o_valid !== 1'b1 || o_res !== 32'd3 || o_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold%0d got v=%b r=%b %h want v=1 r=0 00000003", i, o_valid, o_ready, o_res); end
        end
        @(negedge clk);
        rdy_in = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b1 || o_res !== 32'd7) begin n_bad++; $display("FAIL bp_next got v=%b %h want v=1 00000007", o_valid, o_res); end
        @(posedge clk); #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", o_valid); end
    endtask

`ifdef ALU_MULDIV_EN
    task automatic test_muldiv;
        logic [4:0]  t_op  [8];
        logic [31:0] t_a   [8];
        logic [31:0] t_b   [8];
        logic [31:0] t_res [8];
        int n;
        bit rs;
        t_op  = '{5'd16, 5'd17, 5'd18, 5'd20, 5'd19, 5'd21, 5'd18, 5'd20};
        t_a   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000, 32'h80000000};
        t_b   = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        t_res = '{32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'h0};
        rdy_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(t_op[i], t_a[i], t_b[i]);
            wait_valid(100, n, rs);
            n_cmp++; if (n != 33) begin n_bad++; $display("FAIL md%0d_latency got %0d want 33", i, n); end
            n_cmp++; if (rs !== 1'b0) begin n_bad++; $display("FAIL md%0d_ready got high want low", i); end
            n_cmp++; if (o_res !== t_res[i] || o_illegal !== 1'b0) begin n_bad++; $display("FAIL md%0d_res got %h ill=%b want %h ill=0", i, o_res, o_illegal, t_res[i]); end
        end
        send(5'd19, 32'd100, 32'd7);
        rdy_in = 1'b0;
        wait_valid(100, n, rs);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (o_valid !== 1'b1 || o_res !== 32'd14 || o_ready !== 1'b0) begin n_bad++; $display("FAIL fix_hold%0d got v=%b r=%b %h want v=1 r=0 0000000e", i, o_valid, o_ready, o_res); end
        end
        rdy_in = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL fix_drain got %b want 0", o_valid); end
    endtask
`else
    task automatic test_muldiv;
        for (int i = 16; i <= 21; i++) begin
            send(5'(i), 32'd7, 32'd3);
            n_cmp++; if (o_valid !== 1'b1 || o_illegal !== 1'b1 || o_res !== 32'h0) begin n_bad++; $display("FAIL mdoff%0d got v=%b ill=%b %h want v=1 ill=1 0", i, o_valid, o_illegal, o_res); end
        end
    endtask
`endif

    task automatic test_width8;
        int n;
        send8(5'd0, 8'h7F, 8'h01);
        n_cmp++; if (ovalid8 !== 1'b1 || res8 !== 8'h80 || ovf8 !== 1'b1) begin n_bad++; $display("FAIL w8_add got v=%b %h ovf=%b want v=1 80 ovf=1", ovalid8, res8, ovf8); end
        send8(5'd7, 8'h80, 8'h0F);
        n_cmp++; if (res8 !== 8'hFF || ovf8 !== 1'b0) begin n_bad++; $display("FAIL w8_sra got %h ovf=%b want ff ovf=0", res8, ovf8); end
`ifdef ALU_MULDIV_EN
        send8(5'd19, 8'd200, 8'd7);
        n = 0;
        while (!ovalid8 && n < 50) begin @(posedge clk); #1; n++; end
        n_cmp++; if (n != 9 || res8 !== 8'd28) begin n_bad++; $display("FAIL w8_divu got lat=%0d %h want lat=9 1c", n, res8); end
`endif
    endtask

    task automatic test_reset_mid;
        int n;
        bit rs;
        rdy_in = 1'b0;
        send(5'd0, 32'd1, 32'd1);
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++; if (o_valid !== 1'b0 || o_res !== 32'h0) begin n_bad++; $display("FAIL rstmid_base got v=%b %h want v=0 0", o_valid, o_res); end
        @(negedge clk); rst = 1'b0; rdy_in = 1'b1;
`ifdef ALU_MULDIV_EN
        send(5'd19, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_iter got %b want 0", o_valid); end
        @(negedge clk); rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_discard got v=%b r=%b want v=0 r=1", o_valid, o_ready); end
        send(5'd19, 32'd50, 32'd5);
        wait_valid(100, n, rs);
        n_cmp++; if (n != 33 || o_res !== 32'd10) begin n_bad++; $display("FAIL rstmid_after got lat=%0d %h want lat=33 0000000a", n, o_res); end
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_base_ops;
        test_back_to_back;
        test_backpressure;
        test_muldiv;
        test_width8;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
